itrans_i_stage: RTL and testbench
=================================

// Module: itrans_i_stage
// PURPOSE
//  IFFT stage-I trivial-twiddle rotator. Mirrors the FFT-side -j rotator: samples whose address bits
//  [FFT_STG-1:FFT_STG-2]==2'b11 are multiplied by +j (re'=-im, im'=re); all others pass unchanged.
//  Adds a valid/ready elastic interface (2-entry skid buffer) so the IFFT datapath can stall.
//  Adds in-frame address-sequence checking and frame-end marking.
// PARAMETERS
//  FFT_STG   7   stage index; selects address bits FFT_STG-1 and FFT_STG-2 for rotation decode
//  CNT_W     8   width of completed-frame counter
// PORTS
//  iclk      in   1                 clock; all logic on posedge
//  irst      in   1                 synchronous active-high reset
//  iaddr     in   `TOTAL_STAGE      sample address
//  idata     in   `CPLX_WIDTH       {real,imag}, each `CPLX_WIDTH/2, two's complement
//  ien       in   1                 input valid
//  irdy      out  1                 input ready
//  oaddr     out  `TOTAL_STAGE      address of output sample
//  odata     out  `CPLX_WIDTH       rotated sample
//  oen       out  1                 output valid
//  ordy      in   1                 downstream ready
//  olast     out  1                 qualifies oen: oaddr is all-ones (last sample of frame)
//  oerr      out  1                 1-cycle pulse: accepted iaddr != expected address
//  ofrm_cnt  out  CNT_W             frames completed (olast handshakes), wraps at 2^CNT_W
// BEHAVIOUR
//  - Reset (irst=1 at posedge): oen=0, olast=0, oerr=0, ofrm_cnt=0, oaddr=0, odata=0, irdy=1;
//    skid entry empty; expected address=0. Reset mid-frame discards all buffered samples.
//  - Input accept: ien&irdy. Output transfer: oen&ordy. Hold rule: while oen=1 & ordy=0,
//    oaddr/odata/olast are stable.
//  - Buffer states: EMPTY (oen=0), ONE (output reg valid), TWO (output + skid valid, irdy=0).
//    EMPTY+accept->ONE; ONE+accept&!xfer->TWO; ONE+xfer&!accept->EMPTY; ONE+accept&xfer->ONE;
//    TWO+xfer->ONE (skid moves to output reg). irdy = (state!=TWO), registered.
//  - Latency: accepted sample appears on oen the next cycle when the output is free. Full
//    throughput (1 sample/cycle) with ordy held high.
//  - Rotation, applied at accept time: if {iaddr[FFT_STG-1],iaddr[FFT_STG-2]}==2'b11:
//    re_out = -im_in, im_out = re_in. Otherwise data passes unmodified. Address passes unmodified.
//  - Negation is full-width two's complement; without the option, -(-2^(N-1)) wraps to -2^(N-1).
//  - Sequence check: expected address exp starts at 0. On accept, oerr pulses the next cycle
//    if iaddr != exp. exp <= iaddr+1 (mod 2^`TOTAL_STAGE) on every accept, so the checker
//    resyncs after an error. oerr is independent of ordy.
//  - olast = (oaddr == all-ones), carried with the sample.
//  - ofrm_cnt increments on each oen&ordy&olast.
//  - Simultaneous accept and transfer in TWO is impossible (irdy=0). Accept in EMPTY with
//    ordy=1 does not bypass; the sample still takes 1 cycle.
// CONFIGURATION
//  ITRANS_SAT_EN defined: negation of the most-negative value saturates to +2^(N-1)-1.
//    Adds 1-bit sticky output osat, set on any saturation event, cleared by irst.
//  Not defined: wrap-around negation, as above; osat port absent.
// TESTING
//  1. Reset then addr 0..2^`TOTAL_STAGE-1 with ordy=1, FFT_STG=7, sample addr 96
//     re=100 im=-50 -> out re=50 im=100. Addr 32 passes unchanged. oerr never pulses.
//     olast on the final addr; ofrm_cnt=1.
//  2. Stream with ordy toggled 1,0,0,1 per cycle -> no loss or duplication. irdy=0 only in the
//     TWO state. Output data held stable during stalls.
//  3. Addr sequence 0,1,2,5,6 -> single oerr pulse one cycle after accepting 5. No oerr for 6.
//  4. Rotated sample with im=-2^(N-1):
//     no macro  -> re_out=-2^(N-1).
//     ITRANS_SAT_EN -> re_out=2^(N-1)-1 and osat=1.
//  5. irst asserted with two samples buffered -> next cycle oen=0, irdy=1, ofrm_cnt=0.
//     A new frame starting at addr 0 produces no oerr.
//  6. 256 full frames with CNT_W=8 -> ofrm_cnt wraps to 0.

Source files
------------

// File: rtl/itrans_i_stage.sv
// rtl/itrans_i_stage.sv - IFFT stage-I +j trivial-twiddle rotator with 2-entry skid buffer and address checking
// Optional build macro: ITRANS_SAT_EN (saturating negation plus sticky osat output).
`ifndef TOTAL_STAGE
`define TOTAL_STAGE 7
`endif
`ifndef CPLX_WIDTH
`define CPLX_WIDTH 32
`endif

module itrans_i_stage #(
  parameter int FFT_STG = 7,
  parameter int CNT_W   = 8
) (
  input  logic                     iclk,
  input  logic                     irst,
  input  logic [`TOTAL_STAGE-1:0]  iaddr,
  input  logic [`CPLX_WIDTH-1:0]   idata,
  input  logic                     ien,
  output logic                     irdy,
  output logic [`TOTAL_STAGE-1:0]  oaddr,
  output logic [`CPLX_WIDTH-1:0]   odata,
  output logic                     oen,
  input  logic                     ordy,
  output logic                     olast,
  output logic                     oerr,
  output logic [CNT_W-1:0]         ofrm_cnt
`ifdef ITRANS_SAT_EN
  ,
  output logic                     osat
`endif
);

  localparam int AW = `TOTAL_STAGE;
  localparam int DW = `CPLX_WIDTH;
  localparam int HW = DW / 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic          accept, xfer;
  logic          ld_in, ld_skid, ld_mv;

  logic signed [HW-1:0] in_re, in_im, neg_im;
  logic                 rot;
  logic [DW-1:0]        rot_data;
  logic                 in_last;

  logic [AW-1:0] out_addr, skid_addr;
  logic [DW-1:0] out_data, skid_data;
  logic          out_last, skid_last;
  logic          irdy_q;
  logic          oerr_q;
  logic [AW-1:0] exp_addr;
  logic [CNT_W-1:0] frm_cnt;

  assign in_re   = idata[DW-1:HW];
  assign in_im   = idata[HW-1:0];
  assign rot     = iaddr[FFT_STG-1] & iaddr[FFT_STG-2];
  assign in_last = &iaddr;

`ifdef ITRANS_SAT_EN
  localparam logic signed [HW-1:0] NEG_MIN = {1'b1, {(HW-1){1'b0}}};
  localparam logic signed [HW-1:0] POS_MAX = {1'b0, {(HW-1){1'b1}}};
  logic sat_evt;
  logic osat_q;

  // Only the most-negative imaginary part can overflow on negation.
  assign sat_evt = accept & rot & (in_im == NEG_MIN);
  assign neg_im  = (in_im == NEG_MIN) ? POS_MAX : -in_im;
`else
  assign neg_im  = -in_im;
`endif

  assign rot_data = rot ? {neg_im, in_re} : idata;

  assign oen    = (state_q != ST_EMPTY);
  assign irdy   = irdy_q;
  assign accept = ien & irdy_q;
  assign xfer   = oen & ordy;

  always_ff @(posedge iclk) begin
    if (irst) state_q <= ST_EMPTY;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ld_in   = 1'b0;
    ld_skid = 1'b0;
    ld_mv   = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          ld_in   = 1'b1;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        case ({accept, xfer})
          2'b10: begin
            ld_skid = 1'b1;
            state_d = ST_TWO;
          end
          2'b01: state_d = ST_EMPTY;
          2'b11: ld_in = 1'b1;
          default: state_d = ST_ONE;
        endcase
      end
      ST_TWO: begin
        if (xfer) begin
          ld_mv   = 1'b1;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      out_addr  <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      skid_addr <= '0;
      skid_data <= '0;
      skid_last <= 1'b0;
      irdy_q    <= 1'b1;
    end else begin
      if (ld_in) begin
        out_addr <= iaddr;
        out_data <= rot_data;
        out_last <= in_last;
      end else if (ld_mv) begin
        out_addr <= skid_addr;
        out_data <= skid_data;
        out_last <= skid_last;
      end
      if (ld_skid) begin
        skid_addr <= iaddr;
        skid_data <= rot_data;
        skid_last <= in_last;
      end
      irdy_q <= (state_d != ST_TWO);
    end
  end

  // The checker always re-anchors on the accepted address, so one bad address yields one pulse.
  always_ff @(posedge iclk) begin
    if (irst) begin
      exp_addr <= '0;
      oerr_q   <= 1'b0;
    end else begin
      oerr_q <= accept & (iaddr != exp_addr);
      if (accept) exp_addr <= iaddr + 1'b1;
    end
  end

  always_ff @(posedge iclk) begin
    if (irst)                    frm_cnt <= '0;
    else if (xfer && out_last)   frm_cnt <= frm_cnt + 1'b1;
  end

`ifdef ITRANS_SAT_EN
  always_ff @(posedge iclk) begin
    if (irst)         osat_q <= 1'b0;
    else if (sat_evt) osat_q <= 1'b1;
  end
  assign osat = osat_q;
`endif

  assign oaddr    = out_addr;
  assign odata    = out_data;
  assign olast    = oen & out_last;
  assign oerr     = oerr_q;
  assign ofrm_cnt = frm_cnt;

endmodule

// File: tb/tb_itrans_i_stage.sv
// tb/tb_itrans_i_stage.sv - randomized self-checking bench for itrans_i_stage against a queue-based reference model
`ifndef TOTAL_STAGE
`define TOTAL_STAGE 7
`endif
`ifndef CPLX_WIDTH
`define CPLX_WIDTH 32
`endif

module tb_itrans_i_stage;
  localparam int AW  = `TOTAL_STAGE;
  localparam int DW  = `CPLX_WIDTH;
  localparam int HW  = DW / 2;
  localparam int STG = 7;
  localparam int NS  = 2 ** AW;
  localparam int HMAX = 2 ** (HW - 1) - 1;

  logic          iclk = 1'b0;
  logic          irst, ien, irdy, oen, ordy, olast, oerr;
  logic [AW-1:0] iaddr, oaddr;
  logic [DW-1:0] idata, odata;
  logic [7:0]    ofrm_cnt;
`ifdef ITRANS_SAT_EN
  logic          osat;
`endif

  always #5 iclk = ~iclk;

  itrans_i_stage #(.FFT_STG(STG), .CNT_W(8)) dut (
    .iclk(iclk), .irst(irst), .iaddr(iaddr), .idata(idata), .ien(ien), .irdy(irdy),
    .oaddr(oaddr), .odata(odata), .oen(oen), .ordy(ordy), .olast(olast), .oerr(oerr),
    .ofrm_cnt(ofrm_cnt)
`ifdef ITRANS_SAT_EN
    , .osat(osat)
`endif
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          l;
  } smp_t;

  smp_t          mq[$];
  logic [AW-1:0] src_a[$];
  logic [DW-1:0] src_d[$];
  int            exp_a = 0;
  bit            err_pend = 0;
  int            frm = 0;
  bit            sat_m = 0;
  int            phase = 0;
  int            oerr_seen = 0;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  // Reference rotation: quadrant 3 of the address (bits STG-1:STG-2 == 3) is multiplied by +j.
  function automatic logic [DW-1:0] ref_rot(input int a, input logic [DW-1:0] d, output bit sat);
    int re, im, nre;
    logic [DW-1:0] r;
    re  = int'($signed(d[DW-1:HW]));
    im  = int'($signed(d[HW-1:0]));
    sat = 0;
    if (((a >> (STG - 2)) % 4) != 3) return d;
    nre = -im;
    if (nre > HMAX) begin
`ifdef ITRANS_SAT_EN
      nre = HMAX;
      sat = 1;
`else
      nre = nre - 2 ** HW;
`endif
    end
    r = {nre[HW-1:0], re[HW-1:0]};
    return r;
  endfunction

  task automatic cycle(input bit want, input bit rdy);
    bit   acc, xf, s;
    smp_t e;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    ien   = want && (src_a.size() > 0);
    iaddr = (src_a.size() > 0) ? src_a[0] : '0;
    idata = (src_d.size() > 0) ? src_d[0] : '0;
    ordy  = rdy;
    @(negedge iclk);
    check("oen", oen, mq.size() > 0);
    check("irdy", irdy, mq.size() < 2);
    check("oerr", oerr, err_pend);
    check("ofrm_cnt", ofrm_cnt, frm);
`ifdef ITRANS_SAT_EN
    check("osat", osat, sat_m);
`endif
    if (mq.size() > 0) begin
      check("oaddr", oaddr, mq[0].a);
      check("odata", odata, mq[0].d);
      check("olast", olast, mq[0].l);
      if (phase == 1 && oaddr == 96) check("rot96", odata, 32'h0032_0064);
      if (phase == 1 && oaddr == 32) check("pass32", odata, 32'h0007_0009);
`ifdef ITRANS_SAT_EN
      if (phase == 4 && oaddr == 96) check("negmin_re", odata[DW-1:HW], 16'h7fff);
`else
      if (phase == 4 && oaddr == 96) check("negmin_re", odata[DW-1:HW], 16'h8000);
`endif
    end
    if (oerr) oerr_seen++;
    acc = ien && irdy;
    xf  = oen && ordy;
    @(posedge iclk);
    #1;
    err_pend = 0;
    if (xf && mq.size() > 0) begin
      e = mq.pop_front();
      if (e.l) frm = (frm + 1) % 256;
    end
    if (acc) begin
      a = src_a.pop_front();
      d = src_d.pop_front();
      e.a = a;
      e.d = ref_rot(int'(a), d, s);
      e.l = (int'(a) == NS - 1);
      if (s) sat_m = 1;
      mq.push_back(e);
      err_pend = (int'(a) != exp_a);
      exp_a = (int'(a) + 1) % NS;
    end
  endtask

  // mode 0: ordy=1, mode 1: ordy pattern 1,0,0,1, mode 2: random ordy
  task automatic run(input int lim, input bit rand_en, input int mode);
    int  n;
    bit  w, r;
    n = 0;
    while ((src_a.size() > 0 || mq.size() > 0) && n < lim) begin
      w = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      case (mode)
        0: r = 1'b1;
        1: r = ((n % 4) == 0) || ((n % 4) == 3);
        default: r = $urandom_range(0, 1);
      endcase
      cycle(w, r);
      n++;
    end
    if (n >= lim) check("drain_timeout", 1, 0);
  endtask

  task automatic push(input int a, input logic [DW-1:0] d);
    src_a.push_back(a[AW-1:0]);
    src_d.push_back(d);
  endtask

  task automatic push_frame();
    for (int a = 0; a < NS; a++) push(a, $urandom);
  endtask

  task automatic do_reset();
    irst = 1'b1;
    ien  = 1'b0;
    ordy = 1'b0;
    @(posedge iclk);
    #1;
    irst = 1'b0;
    mq.delete();
    src_a.delete();
    src_d.delete();
    err_pend = 0;
    exp_a = 0;
    frm = 0;
    sat_m = 0;
    @(negedge iclk);
    check("rst_oen", oen, 0);
    check("rst_irdy", irdy, 1);
    check("rst_oerr", oerr, 0);
    check("rst_olast", olast, 0);
    check("rst_frm", ofrm_cnt, 0);
    check("rst_oaddr", oaddr, 0);
    check("rst_odata", odata, 0);
    @(posedge iclk);
    #1;
  endtask

  initial begin
    irst = 1'b1; ien = 1'b0; ordy = 1'b0; iaddr = '0; idata = '0;
    do_reset();

    phase = 1;
    oerr_seen = 0;
    for (int a = 0; a < NS; a++) begin
      if (a == 96)      push(a, {16'd100, 16'hffce});
      else if (a == 32) push(a, 32'h0007_0009);
      else              push(a, $urandom);
    end
    run(1000, 1'b0, 0);
    check("t1_frm", ofrm_cnt, 1);
    check("t1_noerr", oerr_seen, 0);

    phase = 2;
    push_frame();
    run(3000, 1'b1, 1);
    check("t2_frm", ofrm_cnt, 2);

    phase = 3;
    oerr_seen = 0;
    push(0, $urandom); push(1, $urandom); push(2, $urandom);
    push(5, $urandom); push(6, $urandom);
    run(100, 1'b0, 0);
    check("t3_one_err", oerr_seen, 1);

    phase = 4;
    push(96, {16'd3, 16'h8000});
    push(97, $urandom);
    run(100, 1'b0, 0);
`ifdef ITRANS_SAT_EN
    check("t4_osat", osat, 1);
`endif

    phase = 5;
    push(0, $urandom); push(1, $urandom); push(2, $urandom);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
    check("t5_buffered", mq.size(), 2);
    check("t5_irdy_full", irdy, 0);
    do_reset();
    oerr_seen = 0;
    push_frame();
    run(3000, 1'b1, 2);
    check("t5_noerr", oerr_seen, 0);
    check("t5_frm", ofrm_cnt, 1);

    phase = 6;
    do_reset();
    for (int f = 0; f < 256; f++) push_frame();
    run(40000, 1'b0, 0);
    check("t6_wrap", ofrm_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
